// File: rtl/bsg_nonsynth_dpi_to_axis_buffered_if.sv
// AXI4-Stream bundle between the DPI-fed buffered master and its sink.
// The master modport drives the beat; the slave modport returns tready.
interface bsg_nonsynth_dpi_to_axis_buffered_if #(
    parameter int data_width_p = 32,
    parameter int dest_width_p = 1
);
    logic                      tvalid;
    logic                      tready;
    logic [data_width_p-1:0]   tdata;
    logic [data_width_p/8-1:0] tkeep;
    logic                      tlast;
    logic [dest_width_p-1:0]   tdest;

    modport master (
        output tvalid, tdata, tkeep, tlast, tdest,
        input  tready
    );
    modport slave (
        input  tvalid, tdata, tkeep, tlast, tdest,
        output tready
    );
endinterface

// File: rtl/bsg_nonsynth_dpi_to_axis_buffered.sv
// Nonsynth AXIS master: host pushes beats through DPI into a FIFO drained under tready.
// Define BSG_DPI_TO_AXIS_THROTTLE_EN to add LFSR-driven tvalid throttling and set_throttle().
module bsg_nonsynth_dpi_to_axis_buffered #(
    parameter int data_width_p = 32,
    parameter int els_p        = 4,
    parameter int dest_width_p = 1,
    parameter int cnt_width_p  = 32
) (
    input  logic                                aclk_i,
    input  logic                                aresetn_i,
    bsg_nonsynth_dpi_to_axis_buffered_if.master axis,
    output logic [cnt_width_p-1:0]              beats_o,
    output logic [cnt_width_p-1:0]              packets_o
);
    localparam int kw_lp = data_width_p / 8;
    localparam int ew_lp = dest_width_p + 1 + kw_lp + data_width_p;
    localparam int pw_lp = $clog2(els_p);
    localparam int cw_lp = $clog2(els_p + 1);
    localparam logic [pw_lp-1:0]       last_ptr_lp = pw_lp'(els_p - 1);
    localparam logic [pw_lp-1:0]       one_ptr_lp  = pw_lp'(1);
    localparam logic [cw_lp-1:0]       full_lp     = cw_lp'(els_p);
    localparam logic [cw_lp-1:0]       one_cnt_lp  = cw_lp'(1);
    localparam logic [cnt_width_p-1:0] one_lp      = cnt_width_p'(1);

    logic                   rst_n_q;
    logic [ew_lp-1:0]       mem_q [els_p];
    logic [ew_lp-1:0]       mem_d [els_p];
    logic [pw_lp-1:0]       wptr_q, wptr_d;
    logic [pw_lp-1:0]       rptr_q, rptr_d;
    logic [cw_lp-1:0]       cnt_q, cnt_d;
    logic [cnt_width_p-1:0] beats_q, beats_d;
    logic [cnt_width_p-1:0] packets_q, packets_d;
    logic [7:0]             seen_q, seen_d;
    logic                   staged;
    logic                   hs;
    logic                   throttle;
    logic [ew_lp-1:0]       head;

    // Written only by the host-side DPI calls; a beat is staged while the
    // sequence number differs from the copy captured at the last edge.
    bit [ew_lp-1:0] stg_beat;
    bit [7:0]       push_seq;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) rst_n_q <= 1'b0;
        else            rst_n_q <= 1'b1;
    end

    assign staged = (push_seq != seen_q);
    assign hs     = axis.tvalid & axis.tready;
    assign head   = mem_q[rptr_q];

    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        beats_d   = beats_q;
        packets_d = packets_q;
        seen_d    = push_seq;
        if (staged) begin
            mem_d[wptr_q] = stg_beat;
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + one_ptr_lp;
        end
        if (hs) begin
            rptr_d  = (rptr_q == last_ptr_lp) ? '0 : rptr_q + one_ptr_lp;
            beats_d = beats_q + one_lp;
            if (head[data_width_p+kw_lp]) packets_d = packets_q + one_lp;
        end
        if (staged && !hs)      cnt_d = cnt_q + one_cnt_lp;
        else if (!staged && hs) cnt_d = cnt_q - one_cnt_lp;
    end

    always_ff @(posedge aclk_i or negedge rst_n_q) begin
        if (!rst_n_q) begin
            for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            beats_q   <= '0;
            packets_q <= '0;
            seen_q    <= push_seq;
        end else begin
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            beats_q   <= beats_d;
            packets_q <= packets_d;
            seen_q    <= seen_d;
        end
    end

    assign axis.tdata  = head[data_width_p-1:0];
    assign axis.tkeep  = head[data_width_p +: kw_lp];
    assign axis.tlast  = head[data_width_p+kw_lp];
    assign axis.tdest  = head[ew_lp-1 -: dest_width_p];
    assign axis.tvalid = (cnt_q != '0) & ~throttle;
    assign beats_o     = beats_q;
    assign packets_o   = packets_q;

`ifdef BSG_DPI_TO_AXIS_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        thr_en_q, thr_en_d;
    logic [7:0]  thr_seen_q;
    logic        vld_prev_q;
    logic        hs_prev_q;
    bit          thr_req;
    bit   [7:0]  thr_seq;

    function void set_throttle(input bit en);
        thr_req = en;
        thr_seq = thr_seq + 8'd1;
    endfunction

    always_comb begin
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        thr_en_d = (thr_seq != thr_seen_q) ? thr_req : thr_en_q;
    end

    // Only mask when no beat is being held for the sink.
    assign throttle = thr_en_q & (lfsr_q[1:0] == 2'b00) & (~vld_prev_q | hs_prev_q);

    always_ff @(posedge aclk_i or negedge rst_n_q) begin
        if (!rst_n_q) begin
            lfsr_q     <= 16'hACE1;
            thr_en_q   <= 1'b1;
            thr_seen_q <= thr_seq;
            vld_prev_q <= 1'b0;
            hs_prev_q  <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            thr_en_q   <= thr_en_d;
            thr_seen_q <= thr_seq;
            vld_prev_q <= axis.tvalid;
            hs_prev_q  <= hs;
        end
    end
`else
    assign throttle = 1'b0;
`endif

    function bit push(input bit [data_width_p-1:0] data,
                      input longint unsigned       keep,
                      input bit                    last,
                      input bit [dest_width_p-1:0] dest);
        if ((keep >> kw_lp) != 64'd0) $error("push: keep bits beyond tkeep width");
        if (!(aresetn_i && rst_n_q) || cnt_q == full_lp || push_seq != seen_q) return 1'b0;
        stg_beat = {dest, last, keep[kw_lp-1:0], data};
        push_seq = push_seq + 8'd1;
        return 1'b1;
    endfunction

    function int count();
        return int'(cnt_q);
    endfunction

    function bit is_full();
        return cnt_q == full_lp;
    endfunction

    function bit is_empty();
        return cnt_q == '0;
    endfunction

    always @(posedge aclk_i) begin
        if (rst_n_q && $isunknown(axis.tready)) $error("tready_i is X out of reset");
    end
endmodule
